shared_reg_arb: RTL and testbench

SHARED_REG_ARB -- requirements
Module: shared_reg_arb

---
 rtl/shared_reg_arb.sv | 153 +++++++++++++++
 tb/tb_shared_reg_arb.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/shared_reg_arb.sv
// shared_reg_arb: four requesters compete for write access to one shared
// register. The grant is round-robin; a holder is preempted after MAX_HOLD
// consecutive cycles while another requester waits.
//
// Ports:
//   clk      - single clock, rising edge
//   reset    - synchronous, active-high
//   req_i    - per-requester write request, bit k = requester k
//   data_i   - write data, lane k = data_i[k*WIDTH +: WIDTH]
//   gnt_o    - registered one-hot grant, zero when idle
//   owner_o  - index of the grant holder, meaningful only while busy_o=1
//   busy_o   - 1 whenever gnt_o is non-zero
//   q_o      - shared register contents
module shared_reg_arb #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         req_i,
  input  logic [4*WIDTH-1:0] data_i,
  output logic [3:0]         gnt_o,
  output logic [1:0]         owner_o,
  output logic               busy_o,
  output logic [WIDTH-1:0]   q_o
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OWNED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       owner_q, owner_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [3:0]       hold_cnt_q, hold_cnt_d;

  logic [WIDTH-1:0] lane_sel;
  logic             own_req;
  logic [3:0]       others;
  logic [1:0]       pick_idle;
  logic [1:0]       pick_next;
  logic             grant_new;
  logic [1:0]       new_idx;

  // First set bit of req at or after start, wrapping modulo 4. Scanning from
  // the farthest offset down lets the nearest hit overwrite earlier ones.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = start;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  // Next-state, grant and write decision.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    busy_d     = busy_q;
    q_d        = q_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    grant_new  = 1'b0;
    new_idx    = '0;

    lane_sel = '0;
    for (int k = 0; k < 4; k++) begin
      if (owner_q == 2'(k)) lane_sel = data_i[k*WIDTH +: WIDTH];
    end

    own_req   = req_i[owner_q];
    others    = req_i & ~(4'b0001 << owner_q);
    pick_idle = rr_pick(req_i, rr_ptr_q);
    pick_next = rr_pick(others, owner_q + 2'd1);

    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          grant_new = 1'b1;
          new_idx   = pick_idle;
        end
      end
      S_OWNED: begin
        if (!own_req) begin
          // Release edge: no write.
          hold_cnt_d = '0;
          if (|others) begin
            grant_new = 1'b1;
            new_idx   = pick_next;
          end else begin
            state_d = S_IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
          end
        end else begin
          // Holder still requesting: it writes, including on a preempt edge.
          q_d = lane_sel;
          if ((hold_cnt_q == HOLD_LAST) && (|others)) begin
            grant_new = 1'b1;
            new_idx   = pick_next;
          end else if (hold_cnt_q != HOLD_LAST) begin
            hold_cnt_d = hold_cnt_q + 4'd1;
          end
        end
      end
      default: ;
    endcase

    if (grant_new) begin
      state_d    = S_OWNED;
      gnt_d      = 4'b0001 << new_idx;
      owner_d    = new_idx;
      busy_d     = 1'b1;
      hold_cnt_d = '0;
      rr_ptr_d   = new_idx + 2'd1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      busy_q     <= 1'b0;
      q_q        <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      busy_q     <= busy_d;
      q_q        <= q_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign owner_o = owner_q;
  assign busy_o  = busy_q;
  assign q_o     = q_q;

endmodule

// File: tb/tb_shared_reg_arb.sv
// Testbench for shared_reg_arb: a directed vector table for the main
// arbitration/write paths, plus hand-written sequences for round-robin
// rotation (MAX_HOLD=4 and MAX_HOLD=1), hold saturation and lane isolation.
module tb_shared_reg_arb;

  logic        clk;
  logic        reset;
  logic [3:0]  req_i;
  logic [31:0] data_i;
  logic [3:0]  gnt_o, gnt1_o;
  logic [1:0]  owner_o, owner1_o;
  logic        busy_o, busy1_o;
  logic [7:0]  q_o, q1_o;

  int n_cmp = 0;
  int n_err = 0;

  shared_reg_arb #(.WIDTH(8), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .data_i(data_i),
    .gnt_o(gnt_o), .owner_o(owner_o), .busy_o(busy_o), .q_o(q_o)
  );

  shared_reg_arb #(.WIDTH(8), .MAX_HOLD(1)) dut_h1 (
    .clk(clk), .reset(reset), .req_i(req_i), .data_i(data_i),
    .gnt_o(gnt1_o), .owner_o(owner1_o), .busy_o(busy1_o), .q_o(q1_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic [7:0]  q;
    logic        chk_owner;
  } vec_t;

  vec_t vecs [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    req_i  = '0;
    data_i = '0;
    tick();
    tick();
    chk("rst gnt", 32'(gnt_o), 32'h0);
    chk("rst owner", 32'(owner_o), 32'h0);
    chk("rst busy", 32'(busy_o), 32'h0);
    chk("rst q", 32'(q_o), 32'h0);
    reset = 1'b0;
  endtask

  function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic [31:0] data,
                              input logic [3:0] gnt, input logic [1:0] owner, input logic busy,
                              input logic [7:0] q, input logic chk_owner);
    vec_t v;
    v.rst = rst; v.req = req; v.data = data; v.gnt = gnt; v.owner = owner;
    v.busy = busy; v.q = q; v.chk_owner = chk_owner;
    return v;
  endfunction

  initial begin
    int ow, ow_prev;
    logic [7:0] exp_q;

    reset  = 1'b1;
    req_i  = '0;
    data_i = '0;

    // rst req    data           gnt    own busy q   chk_owner
    vecs[0]  = mk(0, 4'b0100, 32'h11A52233, 4'b0100, 2, 1, 8'h00, 1);
    vecs[1]  = mk(0, 4'b0100, 32'h11A52233, 4'b0100, 2, 1, 8'hA5, 1);
    vecs[2]  = mk(0, 4'b0110, 32'h115A2233, 4'b0100, 2, 1, 8'h5A, 1);
    vecs[3]  = mk(0, 4'b0010, 32'h115A7733, 4'b0010, 1, 1, 8'h5A, 1);
    vecs[4]  = mk(0, 4'b1000, 32'h995A7733, 4'b1000, 3, 1, 8'h5A, 1);
    vecs[5]  = mk(0, 4'b0000, 32'h995A7733, 4'b0000, 0, 0, 8'h5A, 0);
    vecs[6]  = mk(0, 4'b0000, 32'h995A7733, 4'b0000, 0, 0, 8'h5A, 0);
    vecs[7]  = mk(0, 4'b0001, 32'h995A77C3, 4'b0001, 0, 1, 8'h5A, 1);
    vecs[8]  = mk(0, 4'b0001, 32'h995A77C4, 4'b0001, 0, 1, 8'hC4, 1);
    vecs[9]  = mk(0, 4'b1001, 32'hEE5A77C5, 4'b0001, 0, 1, 8'hC5, 1);
    vecs[10] = mk(0, 4'b1001, 32'hEE5A77C6, 4'b0001, 0, 1, 8'hC6, 1);
    vecs[11] = mk(0, 4'b1001, 32'hEE5A77C7, 4'b1000, 3, 1, 8'hC7, 1);
    vecs[12] = mk(0, 4'b1001, 32'h3C5A77C8, 4'b1000, 3, 1, 8'h3C, 1);
    vecs[13] = mk(1, 4'b1001, 32'h3C5A77C8, 4'b0000, 0, 0, 8'h00, 1);
    vecs[14] = mk(0, 4'b1001, 32'h3C5A77C8, 4'b0001, 0, 1, 8'h00, 1);
    vecs[15] = mk(0, 4'b1001, 32'h3C5A77D0, 4'b0001, 0, 1, 8'hD0, 1);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      reset  = vecs[i].rst;
      req_i  = vecs[i].req;
      data_i = vecs[i].data;
      tick();
      chk($sformatf("v%0d gnt", i), 32'(gnt_o), 32'(vecs[i].gnt));
      chk($sformatf("v%0d busy", i), 32'(busy_o), 32'(vecs[i].busy));
      chk($sformatf("v%0d q", i), 32'(q_o), 32'(vecs[i].q));
      if (vecs[i].chk_owner) chk($sformatf("v%0d owner", i), 32'(owner_o), 32'(vecs[i].owner));
    end
    reset = 1'b0;

    // All four requesting: 4-cycle turns (MAX_HOLD=4) vs. per-cycle rotation (MAX_HOLD=1).
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      req_i = 4'b1111;
      for (int k = 0; k < 4; k++) data_i[k*8 +: 8] = 8'(k*64 + e);
      tick();
      ow = ((e - 1) / 4) % 4;
      chk($sformatf("rr4 e%0d gnt", e), 32'(gnt_o), 32'(1 << ow));
      chk($sformatf("rr4 e%0d owner", e), 32'(owner_o), 32'(ow));
      if (e >= 2) begin
        ow_prev = ((e - 2) / 4) % 4;
        exp_q = 8'(ow_prev*64 + e);
        chk($sformatf("rr4 e%0d q", e), 32'(q_o), 32'(exp_q));
      end
      ow = (e - 1) % 4;
      chk($sformatf("rr1 e%0d gnt", e), 32'(gnt1_o), 32'(1 << ow));
      if (e >= 2) begin
        ow_prev = (e - 2) % 4;
        exp_q = 8'(ow_prev*64 + e);
        chk($sformatf("rr1 e%0d q", e), 32'(q1_o), 32'(exp_q));
      end
    end

    // Lone requester keeps the grant; hold counter saturates, then preempts at once.
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      req_i  = 4'b0010;
      data_i = {8'hFF, 8'hEE, 8'(16 + i), 8'hDD};
      tick();
      chk($sformatf("solo c%0d gnt", i), 32'(gnt_o), 32'h2);
      if (i >= 2) chk($sformatf("solo c%0d q", i), 32'(q_o), 32'(16 + i));
    end
    chk("solo hold_cnt", 32'(dut.hold_cnt_q), 32'h3);
    req_i = 4'b0011;
    tick();
    chk("solo preempt gnt", 32'(gnt_o), 32'h1);
    chk("solo preempt owner", 32'(owner_o), 32'h0);
    chk("solo preempt q", 32'(q_o), 32'h1A);

    // Non-granted lanes toggle randomly; only lane 2 may reach q_o.
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      req_i  = 4'b0100;
      data_i = {8'($urandom), 8'(i), 8'($urandom), 8'($urandom)};
      tick();
      if (i >= 2) chk($sformatf("iso c%0d q", i), 32'(q_o), 32'(i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
